key_debounce_repeat: RTL and testbench
======================================

Name: key_debounce_repeat

Overview:
Conditions the four raw, active-low DE1-SoC push-buttons before they reach the keys PIO of the HPS/Qsys system, and so sits directly upstream of keys_export. Per key it synchronises the input, debounces it with a counter, and presents a clean active-high level. It also emits single-cycle press, release and auto-repeat event pulses that the annealer control logic uses to step parameters.

Parameters:
NUM_KEYS, 4, number of independent key channels
SYNC_STAGES, 2, flip-flop synchroniser depth (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz; >=2)
REPEAT_DELAY, 25000000, cycles from the press pulse to the first repeat pulse (>=2)
REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (>=2)

Ports:
clk_clk  input  1  system clock (50 MHz)
reset_reset  input  1  asynchronous, active-high reset
key_n_in  input  NUM_KEYS  raw button pins, 0 = pressed, asynchronous
repeat_mask  input  NUM_KEYS  1 = auto-repeat enabled for that key
keys_export  output  NUM_KEYS  debounced level, 1 = pressed; drives the keys PIO
key_press  output  NUM_KEYS  1-cycle pulse on an accepted press
key_release  output  NUM_KEYS  1-cycle pulse on an accepted release
key_repeat  output  NUM_KEYS  1-cycle pulse on each auto-repeat tick
any_event  output  1  registered OR of all press, release and repeat pulses

Behaviour:
- One clock; reset is asynchronous and active-high. All flops clear when reset_reset is asserted; there are no synchronous resets.
- Reset values:
  - Synchroniser stages reset to 1 (released).
  - keys_export, key_press, key_release, key_repeat and any_event reset to 0.
  - All counters reset to 0; every key FSM resets to RELEASED.
- Synchroniser: sync = key_n_in delayed SYNC_STAGES flops. pressed_raw = ~sync.
- Debounce, per key:
  - If pressed_raw == keys_export, the counter clears.
  - Otherwise the counter increments. On the edge where it has counted DEBOUNCE_CYCLES consecutive differing cycles, keys_export toggles and the counter clears.
  - Any single agreeing cycle restarts the count, so glitches shorter than DEBOUNCE_CYCLES are never accepted.
- Latency: a clean input edge reaches keys_export exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles later.
- key_press / key_release assert in the same cycle keys_export rises / falls, for exactly one cycle.
- Repeat FSM, per key, with one shared-width timer:
  - RELEASED: on an accepted press, go to HOLD_WAIT and clear the timer.
  - HOLD_WAIT: the timer counts. When the timer reaches REPEAT_DELAY-1 and the repeat_mask bit is 1, pulse key_repeat, clear the timer and go to REPEATING. If the mask bit is 0, stay in HOLD_WAIT with the timer saturated (no repeat).
  - REPEATING: pulse key_repeat every REPEAT_RATE cycles. If the mask bit drops, stop pulsing and hold the state.
  - Any state: an accepted release returns to RELEASED in the same cycle as key_release. No key_repeat occurs in that cycle.
- Repeat timing: the first repeat fires REPEAT_DELAY cycles after key_press, then every REPEAT_RATE cycles.
- any_event lags the per-key pulses by one cycle.
- Counter widths are $clog2(max value + 1). Counters must never wrap.
- Channels are fully independent. Simultaneous events on several keys each produce their own pulses in the same cycle.
- Reset during a press:
  - Outputs drop to 0 immediately.
  - After reset deasserts with the key still held, the press is re-accepted after SYNC_STAGES + DEBOUNCE_CYCLES cycles with a fresh key_press.

Test Plan:
(Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, SYNC_STAGES=2.)
- Bounce rejection: key_n_in[0] low for 3 cycles, then high -> keys_export stays 0x0 and no pulses are seen.
- Clean press: key_n_in[1] falls at cycle 0 and is held -> keys_export[1] = 1 at cycle 6, with key_press[1] high only in cycle 6.
- Auto-repeat: hold key 1 with repeat_mask = 0xF -> key_repeat[1] at cycles 16, 19 and 22. Release -> key_release[1] 6 cycles later, with no further repeats.
- Masked repeat: repeat_mask = 0x0 and key 2 held for 40 cycles -> key_press[2] only, and key_repeat stays 0.
- Simultaneous keys: all keys fall in the same cycle -> keys_export = 0xF and key_press = 0xF in one cycle, followed by any_event = 1 on the next cycle.
- Reset mid-hold: assert reset_reset at cycle 12 while key 3 is held -> all outputs go 0 asynchronously. Deassert reset with the key still held -> key_press[3] 6 cycles after deassertion.

Source files
------------

// File: rtl/key_debounce_repeat.sv
// Push-button conditioning for the keys PIO: synchronise the active-low pins, debounce them into
// a clean active-high level, and emit press, release and auto-repeat pulses per key.
module key_debounce_repeat #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_n_in,
  input  logic [NUM_KEYS-1:0] repeat_mask,
  output logic [NUM_KEYS-1:0] keys_export,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                any_event
);

  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmrMax =
      ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) - 1;
  localparam int unsigned TmrW   = (TmrMax > 0) ? $clog2(TmrMax + 1) : 1;

  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] DelayLast = TmrW'(REPEAT_DELAY - 1);
  localparam logic [TmrW-1:0] RateLast  = TmrW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    StReleased  = 2'd0,
    StHoldWait  = 2'd1,
    StRepeating = 2'd2
  } rpt_state_e;

  // Synchroniser: stage 0 captures the pin, the last stage feeds the debouncer.
  logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] sync_q, sync_d;
  logic [NUM_KEYS-1:0]                  pressed_raw;

  logic [DbW-1:0]      db_cnt_q [NUM_KEYS];
  logic [DbW-1:0]      db_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] db_accept, db_rise, db_fall;

  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;
  logic                any_q, any_d;

  rpt_state_e          state_q [NUM_KEYS];
  rpt_state_e          state_d [NUM_KEYS];
  logic [TmrW-1:0]     tmr_q [NUM_KEYS];
  logic [TmrW-1:0]     tmr_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] rpt_fire;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], key_n_in};
    pressed_raw = ~sync_q[SYNC_STAGES-1];
  end

  // Count consecutive cycles where the synchronised input disagrees with the accepted level;
  // a single agreeing cycle restarts the count.
  always_comb begin
    db_accept = '0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      db_cnt_d[k] = '0;
      if (pressed_raw[k] != level_q[k]) begin
        if (db_cnt_q[k] == DbLast) begin
          db_accept[k] = 1'b1;
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end
    end
    level_d   = level_q ^ db_accept;
    db_rise   = db_accept & ~level_q;
    db_fall   = db_accept & level_q;
    press_d   = db_rise;
    release_d = db_fall;
    repeat_d  = rpt_fire;
    any_d     = |(press_q | release_q | repeat_q);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_q    <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        db_cnt_q[k] <= '0;
        tmr_q[k]    <= '0;
      end
    end else begin
      sync_q    <= sync_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      any_q     <= any_d;
      db_cnt_q  <= db_cnt_d;
      tmr_q     <= tmr_d;
    end
  end

  // Repeat FSM: state register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        state_q[k] <= StReleased;
      end
    end else begin
      state_q <= state_d;
    end
  end

  // Repeat FSM: next state. Timers saturate at their terminal value while the mask is low.
  always_comb begin
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      state_d[k] = state_q[k];
      tmr_d[k]   = tmr_q[k];
      case (state_q[k])
        StReleased: begin
          tmr_d[k] = '0;
          if (db_rise[k]) begin
            state_d[k] = StHoldWait;
          end
        end
        StHoldWait: begin
          if (db_fall[k]) begin
            state_d[k] = StReleased;
            tmr_d[k]   = '0;
          end else if (rpt_fire[k]) begin
            state_d[k] = StRepeating;
            tmr_d[k]   = '0;
          end else if (tmr_q[k] != DelayLast) begin
            tmr_d[k] = tmr_q[k] + 1'b1;
          end
        end
        StRepeating: begin
          if (db_fall[k]) begin
            state_d[k] = StReleased;
            tmr_d[k]   = '0;
          end else if (rpt_fire[k]) begin
            tmr_d[k] = '0;
          end else if (tmr_q[k] != RateLast) begin
            tmr_d[k] = tmr_q[k] + 1'b1;
          end
        end
        default: begin
          state_d[k] = StReleased;
          tmr_d[k]   = '0;
        end
      endcase
    end
  end

  // Repeat FSM: outputs. A release accepted this cycle suppresses any repeat.
  always_comb begin
    rpt_fire = '0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      if (repeat_mask[k] && !db_fall[k]) begin
        case (state_q[k])
          StHoldWait:  rpt_fire[k] = (tmr_q[k] == DelayLast);
          StRepeating: rpt_fire[k] = (tmr_q[k] == RateLast);
          default:     rpt_fire[k] = 1'b0;
        endcase
      end
    end
  end

  assign keys_export = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;
  assign any_event   = any_q;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Bench for key_debounce_repeat: directed scenarios plus randomized hold/bounce phases, all
// compared cycle by cycle against a history-based reference model.
module tb_key_debounce_repeat;

  localparam int NK = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] mask;
  logic [NK-1:0] keys_export, key_press, key_release, key_repeat;
  logic          any_event;

  int errors = 0;
  int checks = 0;

  key_debounce_repeat #(
    .NUM_KEYS       (NK),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .key_n_in   (key_n),
    .repeat_mask(mask),
    .keys_export(keys_export),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .any_event  (any_event)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: keeps every sampled pin value since reset and decides from that history.
  int            ecount;
  logic [NK-1:0] hist[$];
  logic [NK-1:0] m_level, m_press, m_rel, m_rep;
  logic          m_any;
  int            last_toggle[NK];
  int            press_edge[NK];

  task automatic model_reset();
    ecount = 0;
    hist.delete();
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_rep   = '0;
    m_any   = 1'b0;
    for (int k = 0; k < NK; k++) begin
      last_toggle[k] = 0;
      press_edge[k]  = 0;
    end
  endtask

  task automatic model_step(input logic [NK-1:0] kin, input logic [NK-1:0] msk);
    logic [NK-1:0] pl, rl, rp;
    pl = '0;
    rl = '0;
    rp = '0;
    ecount++;
    hist.push_back(kin);
    m_any = |(m_press | m_rel | m_rep);
    for (int k = 0; k < NK; k++) begin
      bit ready;
      bit differ;
      int d;
      // Level flips once the last DB synchronised samples, all taken since the previous flip,
      // disagree with it. Pins sampled before reset release read as released.
      ready  = (ecount - last_toggle[k]) >= DB;
      differ = 1'b1;
      for (int j = 0; j < DB; j++) begin
        int idx;
        bit raw;
        idx = ecount - SS - j;
        raw = (idx >= 1) ? ~hist[idx-1][k] : 1'b0;
        if (raw == m_level[k]) differ = 1'b0;
      end
      if (ready && differ) begin
        m_level[k]     = ~m_level[k];
        last_toggle[k] = ecount;
        if (m_level[k]) begin
          pl[k]         = 1'b1;
          press_edge[k] = ecount;
        end else begin
          rl[k] = 1'b1;
        end
      end else if (m_level[k] && msk[k]) begin
        d = ecount - press_edge[k];
        if (d == RD || (d > RD && (d - RD) % RR == 0)) rp[k] = 1'b1;
      end
    end
    m_press = pl;
    m_rel   = rl;
    m_rep   = rp;
  endtask

  task automatic compare_all();
    check_eq("keys_export", 32'(keys_export), 32'(m_level));
    check_eq("key_press", 32'(key_press), 32'(m_press));
    check_eq("key_release", 32'(key_release), 32'(m_rel));
    check_eq("key_repeat", 32'(key_repeat), 32'(m_rep));
    check_eq("any_event", 32'(any_event), 32'(m_any));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(key_n, mask);
    #1;
    compare_all();
  endtask

  task automatic settle();
    key_n = '1;
    repeat (12) step();
  endtask

  int            press_cyc;
  int            rel_cyc;
  int            rep_cyc[$];
  int            press_cnt;
  logic [NK-1:0] acc;
  bit            found;
  int            hold_start[NK];
  int            hold_len[NK];

  initial begin
    rst   = 1'b1;
    key_n = '1;
    mask  = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Bounce shorter than the debounce window.
    acc = '0;
    key_n[0] = 1'b0;
    repeat (3) step();
    key_n[0] = 1'b1;
    repeat (10) begin
      step();
      acc |= key_press | key_release | key_repeat | keys_export;
    end
    check_eq("bounce_quiet", 32'(acc), 32'd0);

    // Clean press and auto-repeat on key 1.
    press_cyc = -1;
    rep_cyc.delete();
    key_n[1] = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (key_press[1] && press_cyc < 0) press_cyc = c;
      if (key_repeat[1]) rep_cyc.push_back(c);
    end
    check_eq("press_cycle", 32'(press_cyc), 32'd6);
    check_eq("repeat_count", 32'(rep_cyc.size()), 32'd3);
    if (rep_cyc.size() == 3) begin
      check_eq("repeat0_cycle", 32'(rep_cyc[0]), 32'd16);
      check_eq("repeat1_cycle", 32'(rep_cyc[1]), 32'd19);
      check_eq("repeat2_cycle", 32'(rep_cyc[2]), 32'd22);
    end
    rel_cyc = -1;
    acc = '0;
    key_n[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (key_release[1] && rel_cyc < 0) rel_cyc = c;
      if (rel_cyc >= 0) acc |= key_repeat;
    end
    check_eq("release_cycle", 32'(rel_cyc), 32'd6);
    check_eq("no_repeat_after_release", 32'(acc), 32'd0);
    settle();

    // Masked repeat on key 2.
    mask = '0;
    press_cnt = 0;
    acc = '0;
    key_n[2] = 1'b0;
    repeat (40) begin
      step();
      press_cnt += int'(key_press[2]);
      acc |= key_repeat;
    end
    check_eq("masked_press_count", 32'(press_cnt), 32'd1);
    check_eq("masked_no_repeat", 32'(acc), 32'd0);
    settle();

    // All keys pressed together.
    mask = '1;
    found = 1'b0;
    key_n = '0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (key_press != '0) found = 1'b1;
    end
    check_eq("simul_found", 32'(found), 32'd1);
    check_eq("simul_export", 32'(keys_export), 32'hf);
    check_eq("simul_press", 32'(key_press), 32'hf);
    step();
    check_eq("simul_any_event", 32'(any_event), 32'd1);
    settle();

    // Reset while key 3 is held.
    key_n[3] = 1'b0;
    repeat (12) step();
    rst = 1'b1;
    #1;
    check_eq("rst_export", 32'(keys_export), 32'd0);
    check_eq("rst_pulses", 32'(key_press | key_release | key_repeat), 32'd0);
    check_eq("rst_any", 32'(any_event), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    press_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (key_press[3] && press_cyc < 0) press_cyc = c;
    end
    check_eq("rst_repress_cycle", 32'(press_cyc), 32'd6);
    settle();

    // Randomized holds with glitches; mask changes only while every key is settled released.
    for (int ph = 0; ph < 30; ph++) begin
      mask = NK'($urandom);
      for (int k = 0; k < NK; k++) begin
        hold_start[k] = $urandom_range(0, 20);
        hold_len[k]   = $urandom_range(1, 30);
      end
      for (int c = 0; c < 56; c++) begin
        for (int k = 0; k < NK; k++) begin
          key_n[k] = !(c >= hold_start[k] && c < hold_start[k] + hold_len[k] &&
                       $urandom_range(0, 9) != 0);
        end
        step();
      end
      settle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
